sata_tx_align_sched: RTL and testbench
======================================

Name: sata_tx_align_sched

Overview:
- Transmit-side primitive scheduler between the link layer word stream and the GTX TX datapath, on the 16-bit-per-cycle GTX clock.
- Enforces the SATA rule of ALIGN_COUNT ALIGNP primitives every BURST_PERIOD transmitted dwords, back-pressuring upstream while they are sent.
- Fills any upstream idle dword with SYNCP.
- Supports an immediate forced ALIGN burst for link bring-up and for elastic-buffer recovery.

Parameters:
- BURST_PERIOD, 256: dwords per period, including the ALIGNPs.
- ALIGN_COUNT, 2: ALIGNP dwords per burst; must be ≥1 and < BURST_PERIOD.
- CNT_W, 8: width of the dword counter; must satisfy 2^CNT_W ≥ BURST_PERIOD.

Ports:
- wclk, in, 1: GTX TX word clock.
- rst, in, 1: reset, synchronous, active-low.
- en, in, 1: ALIGN scheduling enable; 0 = pass-through plus SYNC fill only.
- force_align, in, 1: request an ALIGN burst at the next dword boundary.
- in_valid, in, 1: upstream word valid.
- in_ready, out, 1: word accepted this cycle when in_valid & in_ready.
- in_data, in, 16: upstream word; low word of a dword first.
- in_charisk, in, 2: upstream K flags.
- out_data, out, 16: word to the GTX.
- out_charisk, out, 2: K flags to the GTX.
- out_lword, out, 1: high with the second (last) word of each output dword.
- align_active, out, 1: current output dword is an ALIGNP.
- burst_done, out, 1: 1-cycle pulse with the last word of each burst.
- underrun, out, 1: 1-cycle pulse on an upstream protocol violation.

Behaviour:
- Reset values (rst=0):
  - out_data=16'h0000, out_charisk=2'b00, out_lword=0, align_active=0, burst_done=0, underrun=0.
  - phase=0, cnt=BURST_PERIOD-ALIGN_COUNT (the first dword after reset starts a burst if en=1), force latch cleared, state=PASS.
- Reset mid-burst aborts the burst immediately; no partial ALIGN is completed.
- Phase bit toggles every cycle.
  - phase=0 is the first word of a dword, phase=1 the second.
  - All decisions are made only at phase=0.
- Outputs are registered: a word accepted in cycle N appears on out_data in cycle N+1.
- States:
  - PASS: at phase=0, start a burst if (en & cnt==BURST_PERIOD-ALIGN_COUNT) or force_pend. Otherwise:
    - in_valid=1: accept the word; the dword is data.
    - in_valid=0: the dword is SYNC; in_ready stays 1 (no transfer).
  - ALIGN: emits ALIGN_COUNT ALIGNP dwords, then returns to PASS at the next phase=0.
- in_ready:
  - 1 in PASS in any cycle whose output slot carries upstream data.
  - 0 for the whole ALIGN state.
  - 0 at phase=1 of a SYNC dword.
  - Combinational from registered state only; no path from in_valid.
- Word encodings:
  - ALIGNP: low word 16'h4ABC, charisk 01; high word 16'h7B4A, charisk 00.
  - SYNCP: low word 16'h957C, charisk 01; high word 16'hB5B5, charisk 00.
- Upstream contract: if the phase=0 word is accepted, in_valid must be 1 at phase=1.
  - On violation, output 16'hB5B5 with charisk 00 (completing a SYNC-shaped dword) and pulse underrun.
  - The dword still counts.
- Counter:
  - cnt increments by 1 at phase=1 of each non-ALIGN dword while en=1, saturating at BURST_PERIOD-ALIGN_COUNT.
  - cnt clears to 0 when a burst starts.
  - en=0: cnt holds at 0 and no bursts start, except a forced burst.
  - Steady state with en=1: exactly BURST_PERIOD-ALIGN_COUNT non-ALIGN dwords between bursts.
- force_align:
  - Latched into force_pend on any cycle.
  - Cleared when a burst starts.
  - Assertion during a burst is absorbed by the running burst (force_pend is cleared at the burst's own end); no back-to-back bursts.
  - Simultaneous scheduled and forced burst: one burst only.
- align_active is high on both words of each ALIGNP dword.
- burst_done coincides with out_lword of the final ALIGNP.
- en deasserted mid-burst: the burst completes.

Test Plan:
- Reset release, en=1, in_valid=1 constant → the first 4 output words are 4ABC/7B4A/4ABC/7B4A with charisk 01/00/01/00. in_ready=0 in those cycles. burst_done on word 4. Data follows with 1-cycle latency.
- Continuous data, en=1 → bursts repeat every 512 output words. Exactly 508 data words between bursts. No upstream word lost or duplicated (scoreboard).
- in_valid=0 at a phase=0 → output 957C/B5B5 with charisk 01/00. No underrun. cnt increments.
- in_valid dropped at phase=1 after a phase=0 accept → out B5B5, underrun pulse 1 cycle.
- en=0 with force_align pulsed mid-dword → exactly one 2-ALIGNP burst starting at the next phase=0. A repeat pulse during the burst yields no second burst.
- rst=0 asserted during the second ALIGNP → all outputs return to reset values next cycle. After release, a fresh full burst precedes any data.

Source files
------------

// File: rtl/sata_tx_align_sched.sv
// ---------------------------------------------------------------------------
// sata_tx_align_sched
//
// Transmit-side primitive scheduler sitting between the link-layer word
// stream and the GTX TX datapath. One 16-bit word is handled per wclk cycle,
// so every SATA dword takes two cycles: phase 0 carries the low word and
// phase 1 the high word. All scheduling decisions are taken at phase 0.
//
// Functions:
//   * Inserts a burst of ALIGN_COUNT ALIGNP dwords every BURST_PERIOD
//     transmitted dwords while en=1, back-pressuring upstream meanwhile.
//   * Fills any dword for which upstream has no data with SYNCP.
//   * Starts an ALIGN burst at the next dword boundary on force_align,
//     independently of en (link bring-up, elastic-buffer recovery).
//   * Flags an upstream that abandons a dword half way (underrun) and
//     completes that dword with the SYNCP high word.
//
// Ports:
//   wclk         GTX TX word clock
//   rst          synchronous, active-low reset
//   en           ALIGN scheduling enable (0 = pass-through + SYNC fill only)
//   force_align  request an ALIGN burst at the next dword boundary
//   in_valid     upstream word valid
//   in_ready     upstream word accepted when in_valid & in_ready
//   in_data      upstream word, low word of a dword first
//   in_charisk   upstream K flags
//   out_data     registered word to the GTX
//   out_charisk  registered K flags to the GTX
//   out_lword    high with the second (last) word of each output dword
//   align_active high on both words of every ALIGNP dword
//   burst_done   1-cycle pulse with the last word of each burst
//   underrun     1-cycle pulse when upstream drops in_valid mid-dword
// ---------------------------------------------------------------------------
module sata_tx_align_sched #(
    parameter int BURST_PERIOD = 256,  // dwords per period, ALIGNPs included
    parameter int ALIGN_COUNT  = 2,    // ALIGNP dwords per burst
    parameter int CNT_W        = 8     // dword counter width
) (
    input  logic        wclk,
    input  logic        rst,
    input  logic        en,
    input  logic        force_align,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_charisk,
    output logic [15:0] out_data,
    output logic [1:0]  out_charisk,
    output logic        out_lword,
    output logic        align_active,
    output logic        burst_done,
    output logic        underrun
);

    // Number of non-ALIGN dwords between two scheduled bursts; the counter
    // saturates here and a burst is due once it is reached.
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BURST_PERIOD - ALIGN_COUNT);
    // ALIGN dwords still to follow the first one of a burst.
    localparam logic [CNT_W-1:0] ACNT_INIT = CNT_W'(ALIGN_COUNT - 1);

    // Primitive encodings (low word carries the K28.x control character).
    localparam logic [15:0] ALIGN_LO = 16'h4ABC;
    localparam logic [15:0] ALIGN_HI = 16'h7B4A;
    localparam logic [15:0] SYNC_LO  = 16'h957C;
    localparam logic [15:0] SYNC_HI  = 16'hB5B5;
    localparam logic [1:0]  K_LO     = 2'b01;
    localparam logic [1:0]  K_NONE   = 2'b00;

    typedef enum logic {
        ST_PASS,
        ST_ALIGN
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           state;
    logic             phase;       // 0 = low word slot, 1 = high word slot
    logic [CNT_W-1:0] cnt;         // non-ALIGN dwords since the last burst
    logic [CNT_W-1:0] acnt;        // ALIGN dwords left after the current one
    logic             force_pend;  // latched force_align request
    logic             sync_dw;     // current PASS dword is SYNC fill

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] acnt_nx;
    logic             force_pend_nx;
    logic             sync_dw_nx;
    logic [15:0]      data_nx;
    logic [1:0]       charisk_nx;
    logic             align_nx;
    logic             done_nx;
    logic             underrun_nx;

    logic             burst_start;

    // A burst begins at a dword boundary in PASS when either the schedule
    // is due or a forced request is pending. A simultaneous scheduled and
    // forced request collapses into this single start.
    assign burst_start = (state == ST_PASS) && !phase &&
                         ((en && (cnt == CNT_MAX)) || force_pend);

    // in_ready depends only on registered state (and the quasi-static en),
    // never on in_valid, so upstream can build valid from ready without a
    // combinational loop. At phase 1 only a data dword takes a word; a SYNC
    // dword has already committed its slot.
    assign in_ready = (state == ST_PASS) && (phase ? !sync_dw : !burst_start);

    // ------------------------------------------------------------------
    // Next-state and output-word logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below receives a default first, so no
        // path through the branches leaves it unassigned and no latch is
        // inferred.
        state_nx      = state;
        cnt_nx        = cnt;
        acnt_nx       = acnt;
        force_pend_nx = force_pend | force_align;
        sync_dw_nx    = sync_dw;
        data_nx       = 16'h0000;
        charisk_nx    = K_NONE;
        align_nx      = 1'b0;
        done_nx       = 1'b0;
        underrun_nx   = 1'b0;

        if (!phase) begin
            // Low word: decide what this dword is.
            if ((state == ST_ALIGN) || burst_start) begin
                data_nx    = ALIGN_LO;
                charisk_nx = K_LO;
                align_nx   = 1'b1;
                if (burst_start) begin
                    state_nx      = ST_ALIGN;
                    acnt_nx       = ACNT_INIT;
                    cnt_nx        = '0;
                    force_pend_nx = 1'b0;
                end
            end else if (in_valid) begin
                data_nx    = in_data;
                charisk_nx = in_charisk;
                sync_dw_nx = 1'b0;
            end else begin
                data_nx    = SYNC_LO;
                charisk_nx = K_LO;
                sync_dw_nx = 1'b1;
            end
        end else begin
            // High word: complete the dword chosen at phase 0.
            if (state == ST_ALIGN) begin
                data_nx    = ALIGN_HI;
                charisk_nx = K_NONE;
                align_nx   = 1'b1;
                if (acnt == '0) begin
                    // Last ALIGNP of the burst. Any force request that came
                    // in while the burst ran is satisfied by it.
                    done_nx       = 1'b1;
                    state_nx      = ST_PASS;
                    force_pend_nx = 1'b0;
                end else begin
                    acnt_nx = acnt - 1'b1;
                end
            end else begin
                if (!sync_dw && in_valid) begin
                    data_nx    = in_data;
                    charisk_nx = in_charisk;
                end else begin
                    // SYNC fill, or upstream abandoned a data dword: close it
                    // as a SYNC-shaped dword so the GTX stream stays legal.
                    data_nx     = SYNC_HI;
                    charisk_nx  = K_NONE;
                    underrun_nx = !sync_dw;
                end
                if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        end

        // With scheduling disabled the period restarts from zero, so the
        // first scheduled burst after enabling comes a full period later.
        if (!en) begin
            cnt_nx = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this clock edge.
        if (!rst) begin
            state        <= ST_PASS;
            phase        <= 1'b0;
            cnt          <= CNT_MAX;  // first dword after reset opens a burst
            acnt         <= '0;
            force_pend   <= 1'b0;
            sync_dw      <= 1'b0;
            out_data     <= 16'h0000;
            out_charisk  <= K_NONE;
            out_lword    <= 1'b0;
            align_active <= 1'b0;
            burst_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nx;
            phase        <= !phase;
            cnt          <= cnt_nx;
            acnt         <= acnt_nx;
            force_pend   <= force_pend_nx;
            sync_dw      <= sync_dw_nx;
            out_data     <= data_nx;
            out_charisk  <= charisk_nx;
            out_lword    <= phase;
            align_active <= align_nx;
            burst_done   <= done_nx;
            underrun     <= underrun_nx;
        end
    end

endmodule

// File: tb/tb_sata_tx_align_sched.sv
// ---------------------------------------------------------------------------
// tb_sata_tx_align_sched
//
// Self-checking bench for sata_tx_align_sched. A dword-level reference model
// (ALIGN dwords left in the burst, non-ALIGN dwords since the last burst,
// pending force flag) predicts every output word and in_ready; directed
// scenarios add literal checks for the documented corner cases.
// ---------------------------------------------------------------------------
module tb_sata_tx_align_sched;

    localparam int BURST_PERIOD = 256;
    localparam int ALIGN_COUNT  = 2;
    localparam int CNT_W        = 8;
    localparam int GAP          = BURST_PERIOD - ALIGN_COUNT;

    localparam int K_DATA  = 0;
    localparam int K_SYNC  = 1;
    localparam int K_ALIGN = 2;

    logic        wclk;
    logic        rst;
    logic        en;
    logic        force_align;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_charisk;
    logic [15:0] out_data;
    logic [1:0]  out_charisk;
    logic        out_lword;
    logic        align_active;
    logic        burst_done;
    logic        underrun;

    sata_tx_align_sched #(
        .BURST_PERIOD(BURST_PERIOD),
        .ALIGN_COUNT (ALIGN_COUNT),
        .CNT_W       (CNT_W)
    ) dut (
        .wclk        (wclk),
        .rst         (rst),
        .en          (en),
        .force_align (force_align),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_charisk  (in_charisk),
        .out_data    (out_data),
        .out_charisk (out_charisk),
        .out_lword   (out_lword),
        .align_active(align_active),
        .burst_done  (burst_done),
        .underrun    (underrun)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic [21:0] out_vec;
    assign out_vec = {out_data, out_charisk, out_lword, align_active, burst_done, underrun};

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state
    int          m_phase;
    int          m_left;   // ALIGN dwords of the running burst not yet finished
    int          m_since;  // non-ALIGN dwords since the last burst (saturating)
    bit          m_force;
    int          m_kind;
    logic [21:0] exp_vec;
    logic        exp_ready;
    bit          exp_ready_known;
    bit          exp_is_data;
    logic        act_ready;

    function automatic void model_reset();
        m_phase         = 0;
        m_left          = 0;
        m_since         = GAP;
        m_force         = 1'b0;
        m_kind          = K_DATA;
        exp_vec         = '0;
        exp_ready_known = 1'b0;
        exp_is_data     = 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic e, input logic f,
                                       input logic v, input logic [15:0] d,
                                       input logic [1:0] k);
        bit          starting = 1'b0;
        bit          ending   = 1'b0;
        logic [15:0] wd = 16'h0000;
        logic [1:0]  wk = 2'b00;
        bit          lw = 1'b0;
        bit          al = 1'b0;
        bit          dn = 1'b0;
        bit          un = 1'b0;
        if (!r) begin
            model_reset();
            return;
        end
        exp_ready_known = 1'b1;
        exp_is_data     = 1'b0;
        if (m_phase == 0) begin
            if (m_left == 0 && (m_force || (e && m_since == GAP))) begin
                m_left   = ALIGN_COUNT;
                m_since  = 0;
                starting = 1'b1;
            end
            if (m_left > 0)  m_kind = K_ALIGN;
            else if (v)      m_kind = K_DATA;
            else             m_kind = K_SYNC;
            exp_ready = (m_kind != K_ALIGN);
            case (m_kind)
                K_ALIGN: begin wd = 16'h4ABC; wk = 2'b01; al = 1'b1; end
                K_DATA:  begin wd = d;        wk = k;     exp_is_data = 1'b1; end
                default: begin wd = 16'h957C; wk = 2'b01; end
            endcase
        end else begin
            lw        = 1'b1;
            exp_ready = (m_kind == K_DATA);
            if (m_kind == K_ALIGN) begin
                wd     = 16'h7B4A;
                wk     = 2'b00;
                al     = 1'b1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    dn     = 1'b1;
                    ending = 1'b1;
                end
            end else begin
                if (m_kind == K_DATA && v) begin
                    wd          = d;
                    wk          = k;
                    exp_is_data = 1'b1;
                end else begin
                    wd = 16'hB5B5;
                    wk = 2'b00;
                    un = (m_kind == K_DATA);
                end
                if (e && m_since < GAP) m_since = m_since + 1;
            end
        end
        if (!e) m_since = 0;
        m_force = (starting || ending) ? 1'b0 : (m_force | f);
        m_phase = 1 - m_phase;
        exp_vec = {wd, wk, lw, al, dn, un};
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), capture
    // in_ready, advance the model and step to the next falling edge where the
    // registered outputs of that cycle are visible.
    task automatic tick(input logic r, input logic e, input logic f, input logic v,
                        input logic [15:0] d, input logic [1:0] k);
        rst         = r;
        en          = e;
        force_align = f;
        in_valid    = v;
        in_data     = d;
        in_charisk  = k;
        #1;
        act_ready = in_ready;
        model_step(r, e, f, v, d, k);
        @(posedge wclk);
        @(negedge wclk);
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom));
            n_total++;
            if (out_vec !== 22'h0) $display("FAIL reset_outputs: got %h want 000000", out_vec);
            else n_pass++;
        end
    endtask

    task automatic test_first_burst();
        logic [15:0] wd [4];
        logic [1:0]  wk [4];
        wd[0] = 16'h4ABC; wd[1] = 16'h7B4A; wd[2] = 16'h4ABC; wd[3] = 16'h7B4A;
        wk[0] = 2'b01;    wk[1] = 2'b00;    wk[2] = 2'b01;    wk[3] = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, 16'hC000 + 16'(i), 2'b11);
            n_total++;
            if (act_ready !== 1'b0) $display("FAIL first_ready w%0d: got %b want 0", i, act_ready);
            else n_pass++;
            n_total++;
            if ({out_data, out_charisk, align_active} !== {wd[i], wk[i], 1'b1})
                $display("FAIL first_word w%0d: got %h/%b/%b want %h/%b/1",
                         i, out_data, out_charisk, align_active, wd[i], wk[i]);
            else n_pass++;
            n_total++;
            if (burst_done !== (i == 3)) $display("FAIL first_done w%0d: got %b", i, burst_done);
            else n_pass++;
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL first_model w%0d: got %h want %h", i, out_vec, exp_vec);
            else n_pass++;
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 16'hD0D0, 2'b10);
        n_total++;
        if (act_ready !== 1'b1) $display("FAIL first_data_ready: got %b want 1", act_ready);
        else n_pass++;
        n_total++;
        if ({out_data, out_charisk, align_active} !== {16'hD0D0, 2'b10, 1'b0})
            $display("FAIL first_data: got %h/%b/%b want d0d0/10/0", out_data, out_charisk, align_active);
        else n_pass++;
    endtask

    task automatic test_continuous();
        logic [17:0] sb [$];
        logic [17:0] front;
        logic [15:0] d;
        logic [1:0]  k;
        int gap_words = 0;
        int last_done = -1;
        int bursts    = 0;
        for (int i = 0; i < 1600; i++) begin
            d = 16'(i * 7 + 3);
            k = 2'($urandom);
            tick(1'b1, 1'b1, 1'b0, 1'b1, d, k);
            if (act_ready) sb.push_back({d, k});
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL cont_out c%0d: got %h want %h", cyc, out_vec, exp_vec);
            else n_pass++;
            n_total++;
            if (act_ready !== exp_ready) $display("FAIL cont_ready c%0d: got %b want %b", cyc, act_ready, exp_ready);
            else n_pass++;
            if (exp_is_data) begin
                gap_words++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL cont_sb_empty c%0d: got %h want queued word", cyc, out_data);
                end else begin
                    front = sb.pop_front();
                    if ({out_data, out_charisk} !== front)
                        $display("FAIL cont_sb c%0d: got %h want %h", cyc, {out_data, out_charisk}, front);
                    else n_pass++;
                end
            end
            if (burst_done) begin
                bursts++;
                if (last_done >= 0) begin
                    n_total++;
                    if (gap_words !== 2 * GAP) $display("FAIL cont_gap: got %0d want %0d", gap_words, 2 * GAP);
                    else n_pass++;
                    n_total++;
                    if (cyc - last_done !== 2 * BURST_PERIOD)
                        $display("FAIL cont_period: got %0d want %0d", cyc - last_done, 2 * BURST_PERIOD);
                    else n_pass++;
                end
                last_done = cyc;
                gap_words = 0;
            end
        end
        n_total++;
        if (bursts !== 3) $display("FAIL cont_bursts: got %0d want 3", bursts);
        else n_pass++;
        n_total++;
        if (sb.size() !== 0) $display("FAIL cont_sb_left: got %0d want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_sync_fill();
        int aligns = 0;
        logic v0;
        if (m_phase != 0) tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 2'b00);
        // One dword with scheduling off restarts the period from zero.
        tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 2'b00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h3333, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 2'b11);
        n_total++;
        if ({act_ready, out_data, out_charisk, underrun, out_lword} !== {1'b1, 16'h957C, 2'b01, 1'b0, 1'b0})
            $display("FAIL sync_lo: got %b/%h/%b/%b want 1/957c/01/0", act_ready, out_data, out_charisk, underrun);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 16'hEEEE, 2'b11);
        n_total++;
        if ({act_ready, out_data, out_charisk, underrun, out_lword} !== {1'b0, 16'hB5B5, 2'b00, 1'b0, 1'b1})
            $display("FAIL sync_hi: got %b/%h/%b/%b want 0/b5b5/00/0", act_ready, out_data, out_charisk, underrun);
        else n_pass++;
        // SYNC dwords count towards the period: 253 more mixed dwords reach
        // the burst point exactly.
        for (int i = 0; i < GAP - 1; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            tick(1'b1, 1'b1, 1'b0, v0, 16'($urandom), 2'($urandom));
            if (align_active) aligns++;
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL sync_mix_lo c%0d: got %h want %h", cyc, out_vec, exp_vec);
            else n_pass++;
            tick(1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom), 2'($urandom));
            if (align_active) aligns++;
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL sync_mix_hi c%0d: got %h want %h", cyc, out_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (aligns !== 0) $display("FAIL sync_early_align: got %0d want 0", aligns);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, 2'b00);
        n_total++;
        if ({act_ready, align_active, out_data} !== {1'b0, 1'b1, 16'h4ABC})
            $display("FAIL sync_burst_due: got %b/%b/%h want 0/1/4abc", act_ready, align_active, out_data);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 2'b00);
        n_total++;
        if (burst_done !== 1'b1) $display("FAIL sync_burst_end: got %b want 1", burst_done);
        else n_pass++;
    endtask

    task automatic test_underrun();
        if (m_phase != 0) tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 2'b00);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 16'hA55A, 2'b10);
        n_total++;
        if ({out_data, out_charisk, underrun} !== {16'hA55A, 2'b10, 1'b0})
            $display("FAIL under_lo: got %h/%b/%b want a55a/10/0", out_data, out_charisk, underrun);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 2'b11);
        n_total++;
        if ({act_ready, out_data, out_charisk, underrun} !== {1'b1, 16'hB5B5, 2'b00, 1'b1})
            $display("FAIL under_hi: got %b/%h/%b/%b want 1/b5b5/00/1", act_ready, out_data, out_charisk, underrun);
        else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h6789, 2'b00);
        n_total++;
        if ({underrun, out_data} !== {1'b0, 16'h6789})
            $display("FAIL under_pulse: got %b/%h want 0/6789", underrun, out_data);
        else n_pass++;
        n_total++;
        if (out_vec !== exp_vec) $display("FAIL under_model: got %h want %h", out_vec, exp_vec);
        else n_pass++;
    endtask

    task automatic test_force();
        int aligns = 0;
        int dones  = 0;
        if (m_phase != 0) tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 2'b00);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h2000 + 16'(i), 2'b00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h2100, 2'b00);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 16'h2101, 2'b00);  // pulse mid-dword
        n_total++;
        if ({align_active, out_data} !== {1'b0, 16'h2101})
            $display("FAIL force_late: got %b/%h want 0/2101", align_active, out_data);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            // Repeat request during the burst must be absorbed.
            tick(1'b1, 1'b0, 1'(i == 1), 1'b1, 16'h2200 + 16'(i), 2'b00);
            if (align_active) aligns++;
            if (burst_done) dones++;
            n_total++;
            if ({act_ready, align_active} !== 2'b01)
                $display("FAIL force_burst w%0d: got %b/%b want 0/1", i, act_ready, align_active);
            else n_pass++;
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL force_model w%0d: got %h want %h", i, out_vec, exp_vec);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h2300 + 16'(i), 2'b00);
            if (align_active) aligns++;
            if (burst_done) dones++;
        end
        n_total++;
        if (aligns !== 2 * ALIGN_COUNT) $display("FAIL force_align_words: got %0d want %0d", aligns, 2 * ALIGN_COUNT);
        else n_pass++;
        n_total++;
        if (dones !== 1) $display("FAIL force_bursts: got %0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int  lead   = 0;
        bit  seen_data = 1'b0;
        if (m_phase != 0) tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 2'b00);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h3000, 2'b00);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 16'h3001, 2'b00);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b1, 16'h3100, 2'b00);
        n_total++;
        if ({align_active, out_lword, out_data} !== {1'b1, 1'b0, 16'h4ABC})
            $display("FAIL rstmid_second: got %b/%b/%h want 1/0/4abc", align_active, out_lword, out_data);
        else n_pass++;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h3200, 2'b00);
        n_total++;
        if (out_vec !== 22'h0) $display("FAIL rstmid_outputs: got %h want 000000", out_vec);
        else n_pass++;
        // After release a fresh full burst must precede any data.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1, 16'h3300 + 16'(i), 2'b01);
            if (!seen_data) begin
                if (align_active) lead++;
                else seen_data = 1'b1;
            end
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL rstmid_model w%0d: got %h want %h", i, out_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (lead !== 2 * ALIGN_COUNT) $display("FAIL rstmid_lead: got %0d want %0d", lead, 2 * ALIGN_COUNT);
        else n_pass++;
    endtask

    task automatic test_random();
        logic e = 1'b1;
        logic r;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) e = ~e;
            r = ($urandom_range(0, 1499) != 0);
            tick(r, e, 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 7) != 0),
                 16'($urandom), 2'($urandom));
            n_total++;
            if (out_vec !== exp_vec) $display("FAIL rand_out c%0d: got %h want %h", cyc, out_vec, exp_vec);
            else n_pass++;
            if (r && exp_ready_known) begin
                n_total++;
                if (act_ready !== exp_ready) $display("FAIL rand_ready c%0d: got %b want %b", cyc, act_ready, exp_ready);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        en          = 1'b0;
        force_align = 1'b0;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        in_charisk  = 2'b00;
        model_reset();
        @(negedge wclk);
        test_reset();
        test_first_burst();
        test_continuous();
        test_sync_fill();
        test_underrun();
        test_force();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
